// File: rtl/cache_control_nway_pkg.sv
// Shared types and tree pseudo-LRU helpers for the N-way cache controller.
package cache_types;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL
  } state_e;

  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 8;
  localparam int MAX_LVL  = 6;
  localparam int PLRU_W   = 63;

  // Heap layout: node n has children 2n+1 (lower) and 2n+2 (upper).
  function automatic int plru_victim(
    input logic [PLRU_W-1:0] bits,
    input int                levels
  );
    int n;
    int v;
    int d;
    n = 0;
    v = 0;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < levels) begin
        d = bits[n[5:0]] ? 1 : 0;
        v = (v << 1) | d;
        n = 2 * n + 1 + d;
      end
    end
    return v;
  endfunction

  // Returns {node on way's path, new node value} for one tree node.
  function automatic logic [1:0] plru_touch(
    input int node,
    input int levels,
    input int way
  );
    int n;
    int d;
    logic [1:0] r;
    n = 0;
    r = 2'b00;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < levels) begin
        d = (way >> (levels - 1 - l)) & 1;
        if (n == node) r = {1'b1, (d == 0)};
        n = 2 * n + 1 + d;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_control_nway_plru.sv
// Per-set binary-tree pseudo-LRU state with a combinational victim
// for the currently indexed set.
module plru_tree
  import cache_types::*;
#(
  parameter int  NUM_WAYS = DEF_WAYS,
  parameter int  NUM_SETS = DEF_SETS,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] set_idx,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way
);

  logic [NUM_WAYS-2:0] plru_q [NUM_SETS];
  logic [NUM_WAYS-2:0] plru_d;
  logic [PLRU_W-1:0]   cur;
  logic [1:0]          pt;

  always_comb begin
    cur = '0;
    cur[NUM_WAYS-2:0] = plru_q[set_idx];
  end

  assign victim_way = WAY_W'(plru_victim(cur, WAY_W));

  always_comb begin
    plru_d = plru_q[set_idx];
    pt     = 2'b00;
    for (int k = 0; k < NUM_WAYS - 1; k++) begin
      pt = plru_touch(k, WAY_W, int'(touch_way));
      if (pt[1]) plru_d[k] = pt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (touch) begin
      plru_q[set_idx] <= plru_d;
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate
// cache: single-cycle hits, invalid-first then tree-PLRU replacement.
module cache_control_nway
  import cache_types::*;
#(
  parameter int  NUM_WAYS = DEF_WAYS,
  parameter int  NUM_SETS = DEF_SETS,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_W-1:0]    set_idx,
  input  logic [NUM_WAYS-1:0] way_hit,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  input  logic                upstream_read,
  input  logic                upstream_write,
  output logic                upstream_resp,
  output logic                downstream_read,
  output logic                downstream_write,
  input  logic                downstream_resp,
  output logic                downstream_address_sel,
  output logic [WAY_W-1:0]    way_sel,
  output logic [NUM_WAYS-1:0] line_load_en,
  output logic [NUM_WAYS-1:0] word_write_en,
  output logic [NUM_WAYS-1:0] dirty_load_en,
  output logic                new_dirty
);

  state_e           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, miss_way;
  logic             any_hit, any_inv, req, touch;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_hit[w])    hit_way = WAY_W'(w);
      if (!way_valid[w]) inv_way = WAY_W'(w);
    end
  end

  assign any_hit  = |way_hit;
  assign any_inv  = ~&way_valid;
  assign miss_way = any_inv ? inv_way : plru_way;
  assign req      = upstream_read | upstream_write;

  plru_tree #(
    .NUM_WAYS(NUM_WAYS),
    .NUM_SETS(NUM_SETS)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .set_idx   (set_idx),
    .touch     (touch),
    .touch_way (hit_way),
    .victim_way(plru_way)
  );

  always_comb begin
    state_d                = state_q;
    victim_d               = victim_q;
    touch                  = 1'b0;
    upstream_resp          = 1'b0;
    downstream_read        = 1'b0;
    downstream_write       = 1'b0;
    downstream_address_sel = 1'b0;
    way_sel                = '0;
    line_load_en           = '0;
    word_write_en          = '0;
    dirty_load_en          = '0;
    new_dirty              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (any_hit) begin
          upstream_resp = 1'b1;
          way_sel       = hit_way;
          touch         = 1'b1;
          if (upstream_write) begin
            word_write_en = NUM_WAYS'(1) << hit_way;
            dirty_load_en = NUM_WAYS'(1) << hit_way;
            new_dirty     = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = miss_way;
          if (way_valid[miss_way] && way_dirty[miss_way])
            state_d = S_WRITEBACK;
          else
            state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        downstream_write       = 1'b1;
        downstream_address_sel = 1'b1;
        way_sel                = victim_q;
        if (downstream_resp) state_d = S_FILL;
      end
      S_FILL: begin
        downstream_read = 1'b1;
        way_sel         = victim_q;
        if (downstream_resp) begin
          line_load_en  = NUM_WAYS'(1) << victim_q;
          dirty_load_en = NUM_WAYS'(1) << victim_q;
          state_d       = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Transaction-level bench: a tag/valid/dirty cache model with a 4-way
// tree PLRU predicts each request's cycle-by-cycle controller outputs.
module tb_cache_control_nway;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] set_idx;
  logic [3:0] way_hit, way_valid, way_dirty;
  logic       upstream_read, upstream_write, upstream_resp;
  logic       downstream_read, downstream_write, downstream_resp;
  logic       downstream_address_sel;
  logic [1:0] way_sel;
  logic [3:0] line_load_en, word_write_en, dirty_load_en;
  logic       new_dirty;

  int nvec = 0;
  int nerr = 0;

  int tagm [8][4];
  bit vld  [8][4];
  bit drt  [8][4];
  bit tree [8][3];

  cache_control_nway dut (
    .clk                   (clk),
    .rst                   (rst),
    .set_idx               (set_idx),
    .way_hit               (way_hit),
    .way_valid             (way_valid),
    .way_dirty             (way_dirty),
    .upstream_read         (upstream_read),
    .upstream_write        (upstream_write),
    .upstream_resp         (upstream_resp),
    .downstream_read       (downstream_read),
    .downstream_write      (downstream_write),
    .downstream_resp       (downstream_resp),
    .downstream_address_sel(downstream_address_sel),
    .way_sel               (way_sel),
    .line_load_en          (line_load_en),
    .word_write_en         (word_write_en),
    .dirty_load_en         (dirty_load_en),
    .new_dirty             (new_dirty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hitvec(input int s, input int t);
    logic [3:0] r;
    for (int w = 0; w < 4; w++) r[w] = vld[s][w] && (tagm[s][w] == t);
    return r;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int w = 0; w < 4; w++) if (v[w]) return w;
    return 0;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < 4; w++) if (!vld[s][w]) return w;
    return tree[s][0] ? (2 + int'(tree[s][2])) : int'(tree[s][1]);
  endfunction

  task automatic m_touch(input int s, input int w);
    if (w < 2) begin
      tree[s][0] = 1'b1;
      tree[s][1] = (w == 0);
    end else begin
      tree[s][0] = 1'b0;
      tree[s][2] = (w == 2);
    end
  endtask

  task automatic drive_ways(input int s, input int t);
    way_hit = hitvec(s, t);
    for (int w = 0; w < 4; w++) begin
      way_valid[w] = vld[s][w];
      way_dirty[w] = drt[s][w];
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_resp"}, 32'(upstream_resp), 0);
    chk({tag, "_ds"}, 32'({downstream_read, downstream_write}), 0);
    chk({tag, "_en"}, 32'({line_load_en, word_write_en, dirty_load_en}), 0);
  endtask

  task automatic do_req(input int s, input int t, input bit rd,
                        input bit wr, input int dly);
    logic [3:0] hv, msk;
    int  v;
    int  hw;
    bit  done;
    done = 0;
    @(negedge clk);
    set_idx = 3'(s);
    upstream_read = rd;
    upstream_write = wr;
    downstream_resp = 1'b0;
    drive_ways(s, t);
    #1 chk_quiet("idle");
    for (int pass = 0; pass < 2; pass++) begin
      if (!done) begin
        @(negedge clk);
        downstream_resp = 1'b0;
        drive_ways(s, t);
        #1;
        hv = hitvec(s, t);
        if (hv != 4'b0) begin
          hw  = lowest(hv);
          msk = wr ? (4'b1 << hw) : 4'b0;
          chk("hit_resp", 32'(upstream_resp), 1);
          chk("hit_way_sel", 32'(way_sel), 32'(hw));
          chk("hit_word_we", 32'(word_write_en), 32'(msk));
          chk("hit_dirty_le", 32'(dirty_load_en), 32'(msk));
          chk("hit_new_dirty", 32'(new_dirty), 32'(wr));
          chk("hit_ds", 32'({downstream_read, downstream_write}), 0);
          m_touch(s, hw);
          if (wr) drt[s][hw] = 1'b1;
          done = 1;
        end else begin
          v = m_victim(s);
          chk_quiet("miss");
          if (vld[s][v] && drt[s][v]) begin
            for (int i = 0; i <= dly; i++) begin
              @(negedge clk);
              downstream_resp = (i == dly);
              #1;
              chk("wb_write", 32'(downstream_write), 1);
              chk("wb_read", 32'(downstream_read), 0);
              chk("wb_addr_sel", 32'(downstream_address_sel), 1);
              chk("wb_way_sel", 32'(way_sel), 32'(v));
            end
          end
          msk = 4'b1 << v;
          for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            downstream_resp = (i == dly);
            #1;
            chk("fill_read", 32'(downstream_read), 1);
            chk("fill_write", 32'(downstream_write), 0);
            chk("fill_addr_sel", 32'(downstream_address_sel), 0);
            chk("fill_way_sel", 32'(way_sel), 32'(v));
            chk("fill_line_le", 32'(line_load_en),
                (i == dly) ? 32'(msk) : 0);
            chk("fill_dirty_le", 32'(dirty_load_en),
                (i == dly) ? 32'(msk) : 0);
            if (i == dly) chk("fill_new_dirty", 32'(new_dirty), 0);
          end
          tagm[s][v] = t;
          vld[s][v] = 1'b1;
          drt[s][v] = 1'b0;
        end
      end
    end
    @(negedge clk);
    upstream_read = 1'b0;
    upstream_write = 1'b0;
    downstream_resp = 1'b0;
    way_hit = 4'b0;
  endtask

  initial begin
    int s, t, rw;
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 4; w++) begin
        tagm[i][w] = -1;
        vld[i][w] = 0;
        drt[i][w] = 0;
        if (w < 3) tree[i][w] = 0;
      end
    rst = 1'b1;
    set_idx = '0;
    way_hit = '0;
    way_valid = '0;
    way_dirty = '0;
    upstream_read = 1'b0;
    upstream_write = 1'b0;
    downstream_resp = 1'b0;
    @(negedge clk);
    upstream_read = 1'b1;
    #1;
    chk_quiet("reset");
    chk("reset_way_sel", 32'(way_sel), 0);
    @(negedge clk);
    upstream_read = 1'b0;
    rst = 1'b0;

    // Clean read hit in set 2, way 2.
    vld[2][2] = 1;
    tagm[2][2] = 7;
    do_req(2, 7, 1, 0, 0);

    // Write miss with ways 0,1 valid: fill way 2, then write hit.
    vld[5][0] = 1; tagm[5][0] = 1;
    vld[5][1] = 1; tagm[5][1] = 2;
    do_req(5, 9, 0, 1, 1);

    // Set 3 all valid/clean: hits on 0 and 2, miss picks way 1.
    for (int w = 0; w < 4; w++) begin
      vld[3][w] = 1;
      tagm[3][w] = 10 + w;
    end
    do_req(3, 10, 1, 0, 0);
    do_req(3, 12, 1, 0, 0);
    do_req(3, 20, 1, 0, 0);

    // Dirty way 1 becomes the victim: writeback with a 3-cycle delay.
    do_req(3, 20, 0, 1, 0);
    do_req(3, 10, 1, 0, 0);
    do_req(3, 12, 1, 0, 0);
    do_req(3, 30, 1, 0, 3);

    // Multi-hit resolves to the lowest way.
    @(negedge clk);
    set_idx = 3'd0;
    way_hit = 4'b1010;
    way_valid = 4'b1111;
    way_dirty = 4'b0000;
    upstream_read = 1'b1;
    @(negedge clk);
    #1;
    chk("multi_hit_resp", 32'(upstream_resp), 1);
    chk("multi_hit_way", 32'(way_sel), 1);
    chk("multi_hit_we", 32'(word_write_en), 0);
    m_touch(0, 1);
    @(negedge clk);
    upstream_read = 1'b0;
    way_hit = 4'b0;
    way_valid = 4'b0;

    // Read and write together take the write path.
    do_req(2, 7, 1, 1, 0);

    // Reset in the middle of a fill.
    @(negedge clk);
    set_idx = 3'd6;
    upstream_read = 1'b1;
    drive_ways(6, 50);
    @(negedge clk);
    #1 chk("rst_seq_miss_resp", 32'(upstream_resp), 0);
    @(negedge clk);
    #1 chk("rst_seq_fill_read", 32'(downstream_read), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_read", 32'(downstream_read), 0);
    chk("rst_async_way_sel", 32'(way_sel), 0);
    chk("rst_async_line_le", 32'(line_load_en), 0);
    upstream_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int n = 0; n < 3; n++) tree[i][n] = 0;

    // PLRU cleared: set 3 all valid misses into way 0.
    do_req(3, 40, 1, 0, 0);

    for (int k = 0; k < 80; k++) begin
      s = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 5));
      rw = int'($urandom_range(0, 2));
      do_req(s, t, (rw != 1), (rw != 0), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cache_control_nway.md
# cache_control_nway

Control FSM for an N-way set-associative, write-back, write-allocate cache. It generalises the existing direct-mapped controller to parametrised associativity and set count, with invalid-first victim selection, per-set tree pseudo-LRU replacement, and a single-cycle hit response from the lookup state. It sits between the CPU-side upstream handshake and the downstream memory/L2 handshake, and drives the per-way enables of the cache datapath.

## Interface
Parameters:
- NUM_WAYS, 4, associativity; power of two, ≥2
- NUM_SETS, 8, sets; power of two, ≥2
- WAY_W = $clog2(NUM_WAYS), SET_W = $clog2(NUM_SETS) (derived localparams)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- set_idx  in  SET_W  set index of the current request; stable while request held
- way_hit  in  NUM_WAYS  per-way tag match AND valid
- way_valid  in  NUM_WAYS  per-way valid bit of indexed set
- way_dirty  in  NUM_WAYS  per-way dirty bit of indexed set
- upstream_read / upstream_write  in  1 each  request; held until upstream_resp
- upstream_resp  out  1  one-cycle completion pulse
- downstream_read / downstream_write  out  1 each  memory request; held until downstream_resp
- downstream_resp  in  1  memory completion pulse
- downstream_address_sel  out  1  0 = request address, 1 = {victim tag, set_idx}
- way_sel  out  WAY_W  way driving the data/tag output muxes
- line_load_en  out  NUM_WAYS  one-hot; load line from downstream, tag, valid=1
- word_write_en  out  NUM_WAYS  one-hot; merge upstream write data
- dirty_load_en  out  NUM_WAYS  one-hot; load new_dirty into the way's dirty bit
- new_dirty  out  1  value for dirty_load_en

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL. Reset → IDLE; all outputs 0; victim register 0; all PLRU bits 0.
- IDLE: outputs 0. Go to LOOKUP if read|write, else stay.
- LOOKUP:
  - Neither request asserted: go to IDLE, no response.
  - Hit (|way_hit): hit way = lowest set index of way_hit (multi-hit resolves to the lowest index). way_sel = hit way; upstream_resp=1; PLRU touch(set_idx, hit way).
    - Write: word_write_en[hit]=1, dirty_load_en[hit]=1, new_dirty=1.
    - Next state IDLE.
  - Miss: victim = lowest-index invalid way if any way_valid is 0, else PLRU victim. Latch it.
    - Next state WRITEBACK if victim valid and dirty, else FILL.
- WRITEBACK: downstream_write=1, downstream_address_sel=1, way_sel=victim. On downstream_resp go to FILL.
- FILL: downstream_read=1, way_sel=victim. On downstream_resp: line_load_en[victim]=1, dirty_load_en[victim]=1, new_dirty=0; go to LOOKUP. The re-lookup hits and completes the request.
- Read and write both high: treated as write.
- Request dropped during WRITEBACK/FILL: the memory transaction completes. The following LOOKUP returns to IDLE silently.
- PLRU: NUM_WAYS−1 bits per set, binary tree. Node bit 0 = victim in lower half.
  - Touch(w) sets every node on w's path to point away from w.
  - Only hits touch. Fill is followed by a hit, which touches.

## Timing
- Clean hit: request in cycle 0 (IDLE), upstream_resp in cycle 1 (LOOKUP).
- Clean miss: IDLE, LOOKUP, FILL (≥1 cycle, until resp), LOOKUP(resp). Minimum 4 cycles.
- Dirty miss: adds WRITEBACK (≥1 cycle) before FILL. Minimum 5 cycles.
- Downstream request is asserted from the first cycle of the state; downstream_resp is sampled each cycle; the state exits the cycle after resp.
- rst asserted mid-transaction: immediate return to IDLE. Downstream strobes drop asynchronously. PLRU is cleared.

## Structure
- Package cache_types: state enum, default NUM_WAYS/NUM_SETS, plru_victim/plru_touch functions.
- Sub-module plru_tree (params NUM_WAYS, NUM_SETS):
  - Inputs: clk, rst, set_idx, touch, touch_way.
  - Output: victim_way (combinational from the indexed set's bits).

## Test plan
- Reset, set 2, way_hit=4'b0100, read → upstream_resp in cycle 1, way_sel=2, no write/dirty enables.
- Set 5, write, way_valid=4'b0011, no hit → FILL, way_sel=2. On resp: line_load_en=4'b0100. Next LOOKUP with hit way 2: word_write_en=4'b0100, new_dirty=1.
- Set 3, all valid/clean; hits on ways 0 then 2; miss → victim way 1; FILL without WRITEBACK.
- Set 3, victim way 1 dirty → WRITEBACK with downstream_address_sel=1, way_sel=1; 3-cycle resp delay honoured; then FILL.
- way_hit=4'b1010 → hit way 1 chosen. Read+write simultaneously → write path taken.
- rst pulsed mid-FILL → outputs 0 immediately. Next miss in set 3 with all valid → victim way 0.
